// File: rtl/sprite_blitter.sv
// rtl/sprite_blitter.sv - renders or erases one sprite into the 320x240 frame buffer
module sprite_blitter #(
   parameter int          SPRITE_W    = 8,
   parameter int          SPRITE_H    = 8,
   parameter int          ADDR_W      = 6,
   parameter logic [2:0]  TRANSPARENT = 3'b101
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              start,
   input  logic              erase,
   input  logic [2:0]        erase_colour,
   input  logic [8:0]        x_in,
   input  logic [7:0]        y_in,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [2:0]        rom_data,
   output logic              busy,
   output logic              done,
   output logic              plot,
   output logic [8:0]        X,
   output logic [7:0]        Y,
   output logic [2:0]        color
);

   localparam int CW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
   localparam int RW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

   state_t            state_q, state_d;
   logic              flush_q, flush_d;

   // stage A: address counters plus the operands latched at start
   logic [CW-1:0]     col_q, col_d;
   logic [RW-1:0]     row_q, row_d;
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic              valid_a_q, valid_a_d;
   logic [8:0]        x_lat_q, x_lat_d;
   logic [7:0]        y_lat_q, y_lat_d;
   logic              erase_q, erase_d;
   logic [2:0]        ecol_q, ecol_d;

   // stage B: pixel coordinates, aligned with rom_data
   logic              valid_b_q, valid_b_d;
   logic [9:0]        x_b_q, x_b_d;
   logic [8:0]        y_b_q, y_b_d;

   // stage C: write port registers
   logic              plot_q, plot_d;
   logic [8:0]        x_q, x_d;
   logic [7:0]        y_q, y_d;
   logic [2:0]        color_q, color_d;

   logic              last_addr;
   logic              on_screen;

   assign last_addr = (col_q == CW'(SPRITE_W - 1)) && (row_q == RW'(SPRITE_H - 1));

   // state register
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         flush_q <= 1'b0;
      end else begin
         state_q <= state_d;
         flush_q <= flush_d;
      end
   end

   // next-state logic; FLUSH lasts two cycles so the last address drains
   always_comb begin
      state_d = state_q;
      flush_d = flush_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (last_addr) begin
                     state_d = S_FLUSH;
                     flush_d = 1'b0;
                  end
         S_FLUSH: if (flush_q) state_d = S_DONE;
                  else         flush_d = 1'b1;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      busy = (state_q != S_IDLE);
      done = (state_q == S_DONE);
   end

   // datapath registers
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         col_q      <= '0;
         row_q      <= '0;
         rom_addr_q <= '0;
         valid_a_q  <= 1'b0;
         x_lat_q    <= '0;
         y_lat_q    <= '0;
         erase_q    <= 1'b0;
         ecol_q     <= '0;
         valid_b_q  <= 1'b0;
         x_b_q      <= '0;
         y_b_q      <= '0;
         plot_q     <= 1'b0;
         x_q        <= '0;
         y_q        <= '0;
         color_q    <= '0;
      end else begin
         col_q      <= col_d;
         row_q      <= row_d;
         rom_addr_q <= rom_addr_d;
         valid_a_q  <= valid_a_d;
         x_lat_q    <= x_lat_d;
         y_lat_q    <= y_lat_d;
         erase_q    <= erase_d;
         ecol_q     <= ecol_d;
         valid_b_q  <= valid_b_d;
         x_b_q      <= x_b_d;
         y_b_q      <= y_b_d;
         plot_q     <= plot_d;
         x_q        <= x_d;
         y_q        <= y_d;
         color_q    <= color_d;
      end
   end

   // stage A: operand latch on start, then one address per RUN cycle
   always_comb begin
      col_d      = col_q;
      row_d      = row_q;
      rom_addr_d = rom_addr_q;
      valid_a_d  = 1'b0;
      x_lat_d    = x_lat_q;
      y_lat_d    = y_lat_q;
      erase_d    = erase_q;
      ecol_d     = ecol_q;
      if (state_q == S_IDLE && start) begin
         x_lat_d    = x_in;
         y_lat_d    = y_in;
         erase_d    = erase;
         ecol_d     = erase_colour;
         col_d      = '0;
         row_d      = '0;
         rom_addr_d = '0;
         valid_a_d  = 1'b1;
      end else if (state_q == S_RUN && !last_addr) begin
         if (col_q == CW'(SPRITE_W - 1)) begin
            col_d = '0;
            row_d = row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
         rom_addr_d = rom_addr_q + 1'b1;
         valid_a_d  = 1'b1;
      end
   end

   // stage B: full-width sums so off-screen wrap is detectable
   always_comb begin
      valid_b_d = valid_a_q;
      x_b_d     = {1'b0, x_lat_q} + 10'(col_q);
      y_b_d     = {1'b0, y_lat_q} + 9'(row_q);
   end

   // stage C: clip, apply transparency, hold X/Y/color on idle beats
   always_comb begin
      on_screen = valid_b_q && (x_b_q < 10'd320) && (y_b_q < 9'd240);
      if (erase_q) begin
         plot_d  = on_screen;
         color_d = plot_d ? ecol_q : color_q;
      end else begin
         plot_d  = on_screen && (rom_data != TRANSPARENT);
         color_d = plot_d ? rom_data : color_q;
      end
      x_d = plot_d ? x_b_q[8:0] : x_q;
      y_d = plot_d ? y_b_q[7:0] : y_q;
   end

   assign rom_addr = rom_addr_q;
   assign plot     = plot_q;
   assign X        = x_q;
   assign Y        = y_q;
   assign color    = color_q;

endmodule
